// File: rtl/bookkeeping_arbiter.sv
// rtl/bookkeeping_arbiter.sv - round-robin put arbiter with in-order response steering for a shared directory
module bookkeeping_arbiter #(
   parameter int NREQ  = 2,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*35-1:0]         req_data,
   output logic [NREQ-1:0]            resp_valid,
   input  logic [NREQ-1:0]            resp_ready,
   output logic [79:0]                resp_data,
   output logic                       dir_put_valid,
   input  logic                       dir_put_ready,
   output logic [34:0]                dir_put_request,
   input  logic                       dir_get_ready,
   output logic                       dir_get_valid,
   input  logic [79:0]                dir_get_response,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       err_orphan
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);

   logic [IDW-1:0] prio;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] tag_mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [IDW-1:0] head;
   logic           fifo_full;
   logic           fifo_empty;
   logic           put_fire;
   logic           get_fire;
   logic           resp_avail;

   // First requester at or after p (cyclically) with valid set; p when none is valid.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
      logic [IDW-1:0] g;
      logic           found;
      int             idx;
      g     = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!found && v[idx]) begin
            g     = IDW'(idx);
            found = 1'b1;
         end
      end
      return g;
   endfunction

   assign fifo_full  = (count == CW'(DEPTH));
   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr];
   assign inflight   = count;
   assign resp_data  = dir_get_response;

   // Grant selection is purely combinational so a put passes straight through.
   always_comb begin
      grant = rr_pick(req_valid, prio);
   end

   // Put path: offer the granted payload, gated while in reset so nothing is accepted.
   always_comb begin
      dir_put_valid   = RST_N && (|req_valid) && !fifo_full;
      dir_put_request = req_data[35*grant +: 35];
      put_fire        = dir_put_valid && dir_put_ready;
      req_ready       = '0;
      req_ready[grant] = put_fire;
   end

   // Response path: steer the directory head response to the requester that owns the oldest tag.
   always_comb begin
      resp_avail       = RST_N && dir_get_ready && !fifo_empty;
      get_fire         = resp_avail && resp_ready[head];
      dir_get_valid    = get_fire;
      resp_valid       = '0;
      resp_valid[head] = resp_avail;
   end

   // Tag storage needs no reset; only slots between rd_ptr and wr_ptr are ever read as live.
   always_ff @(posedge CLK) begin
      if (put_fire) begin
         tag_mem[wr_ptr] <= grant;
      end
   end

   // Tag FIFO pointers and occupancy; push and pop may coincide when not empty.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (put_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (get_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({put_fire, get_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Round-robin pointer moves just past the winner on each accepted put.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prio <= '0;
      end else if (put_fire) begin
         if (grant == IDW'(NREQ-1)) begin
            prio <= '0;
         end else begin
            prio <= grant + 1'b1;
         end
      end
   end

   // Sticky flag for a directory response that no outstanding put can account for.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_orphan <= 1'b0;
      end else if (dir_get_ready && fifo_empty) begin
         err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bookkeeping_arbiter.sv
// tb/tb_bookkeeping_arbiter.sv - directed self-checking bench for bookkeeping_arbiter
module tb_bookkeeping_arbiter;

   logic         CLK;
   logic         RST_N;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [69:0]  req_data;
   logic [1:0]   resp_valid;
   logic [1:0]   resp_ready;
   logic [79:0]  resp_data;
   logic         dir_put_valid;
   logic         dir_put_ready;
   logic [34:0]  dir_put_request;
   logic         dir_get_ready;
   logic         dir_get_valid;
   logic [79:0]  dir_get_response;
   logic [2:0]   inflight;
   logic         err_orphan;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [34:0] D0 = 35'h2_0000_00A0;
   localparam logic [34:0] D1 = 35'h4_0000_00B1;

   bookkeeping_arbiter #(.NREQ(2), .DEPTH(4)) dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_data         (req_data),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_data        (resp_data),
      .dir_put_valid    (dir_put_valid),
      .dir_put_ready    (dir_put_ready),
      .dir_put_request  (dir_put_request),
      .dir_get_ready    (dir_get_ready),
      .dir_get_valid    (dir_get_valid),
      .dir_get_response (dir_get_response),
      .inflight         (inflight),
      .err_orphan       (err_orphan)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

      RST_N = 1'b0;
      req_valid = 2'b11;
      req_data = {D1, D0};
      resp_ready = 2'b11;
      dir_put_ready = 1'b1;
      dir_get_ready = 1'b1;
      dir_get_response = 80'h0;
      #2;
      check("rst_put_valid", dir_put_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_get_valid", dir_get_valid, 0);
      check("rst_inflight", inflight, 0);
      check("rst_orphan", err_orphan, 0);

      // single put
      step;
      RST_N = 1'b1;
      dir_get_ready = 1'b0;
      req_valid = 2'b01;
      req_data = {D1, 35'h1_2345_6789};
      #1;
      check("single_req", dir_put_request, 35'h1_2345_6789);
      check("single_ready", req_ready, 2'b01);
      step;
      req_valid = 2'b00;
      #1;
      check("single_inflight1", inflight, 1);
      dir_get_ready = 1'b1;
      dir_get_response = 80'hABCD;
      resp_ready = 2'b01;
      #1;
      check("single_resp_valid", resp_valid, 2'b01);
      check("single_get_valid", dir_get_valid, 1);
      check("single_resp_data", resp_data, 80'hABCD);
      step;
      dir_get_ready = 1'b0;
      #1;
      check("single_inflight0", inflight, 0);
      check("single_no_orphan", err_orphan, 0);

      // round-robin from a fresh reset, then fill to full
      RST_N = 1'b0;
      #1;
      RST_N = 1'b1;
      req_data = {D1, D0};
      req_valid = 2'b11;
      resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_grant", req_ready, rr_exp[i]);
         check("rr_request", dir_put_request, rr_exp[i][0] ? D0 : D1);
         step;
      end
      check("full_inflight", inflight, 4);
      check("full_put_valid", dir_put_valid, 0);
      check("full_req_ready", req_ready, 0);

      // pop while full: put still blocked this cycle, accepted on the next
      dir_get_ready = 1'b1;
      #1;
      check("rr_resp0", resp_valid, 2'b01);
      check("full_pop_get", dir_get_valid, 1);
      check("full_pop_put_blocked", dir_put_valid, 0);
      step;
      check("after_pop_put_valid", dir_put_valid, 1);
      check("after_pop_grant", req_ready, 2'b01);
      check("rr_resp1", resp_valid, 2'b10);
      check("rr_get1", dir_get_valid, 1);
      step;
      req_valid = 2'b00;
      #1;
      check("both_fire_inflight", inflight, 3);
      check("rr_resp2", resp_valid, 2'b01);
      step;
      check("rr_resp3", resp_valid, 2'b10);
      step;
      check("rr_resp4", resp_valid, 2'b01);
      step;
      dir_get_ready = 1'b0;
      #1;
      check("rr_drained", inflight, 0);

      // response backpressure on requester 1
      req_valid = 2'b10;
      #1;
      check("bp_put_grant", req_ready, 2'b10);
      step;
      req_valid = 2'b00;
      dir_get_ready = 1'b1;
      resp_ready = 2'b00;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_resp_valid", resp_valid, 2'b10);
         check("bp_get_valid", dir_get_valid, 0);
         step;
      end
      check("bp_inflight", inflight, 1);
      resp_ready = 2'b10;
      #1;
      check("bp_release_get", dir_get_valid, 1);
      step;
      dir_get_ready = 1'b0;
      #1;
      check("bp_inflight0", inflight, 0);
      check("bp_no_orphan", err_orphan, 0);

      // orphan response
      dir_get_ready = 1'b1;
      resp_ready = 2'b11;
      #1;
      check("orph_get_valid", dir_get_valid, 0);
      check("orph_resp_valid", resp_valid, 0);
      check("orph_not_yet", err_orphan, 0);
      step;
      dir_get_ready = 1'b0;
      #1;
      check("orph_set", err_orphan, 1);
      step;
      check("orph_sticky", err_orphan, 1);

      // reset with three outstanding puts
      req_valid = 2'b01;
      for (int i = 0; i < 3; i++) step;
      req_valid = 2'b11;
      dir_get_ready = 1'b1;
      resp_ready = 2'b00;
      #1;
      check("mid_inflight3", inflight, 3);
      RST_N = 1'b0;
      #1;
      check("mid_rst_inflight", inflight, 0);
      check("mid_rst_orphan", err_orphan, 0);
      check("mid_rst_put_valid", dir_put_valid, 0);
      check("mid_rst_req_ready", req_ready, 0);
      check("mid_rst_resp_valid", resp_valid, 0);
      check("mid_rst_get_valid", dir_get_valid, 0);
      dir_get_ready = 1'b0;
      RST_N = 1'b1;
      #1;
      check("post_rst_grant0", req_ready, 2'b01);
      req_valid = 2'b10;
      #1;
      check("post_rst_grant1", req_ready, 2'b10);
      step;
      req_valid = 2'b00;
      #1;
      check("post_rst_inflight", inflight, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bookkeeping_arbiter.md
# bookkeeping_arbiter

Shares one `bookkeeping_directory` instance between `NREQ` requesters (per-core cache front-ends). It round-robin arbitrates 35-bit put requests onto the directory's single put port. It records the winning requester ID in an in-order tag FIFO and steers each 80-bit directory response back to the requester that issued the matching put. It sits between the cores' cache controllers and the `ext_bookkeeping`-style directory port.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `DEPTH`, default 4: maximum outstanding puts; tag-FIFO depth, power of two ≥ 2.

Ports:
- `CLK` in 1: clock; all state updates on rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: requester i presents a put.
- `req_ready` out NREQ: put from requester i accepted this cycle.
- `req_data` in NREQ*35: put payload; requester i occupies bits [35*i+34:35*i].
- `resp_valid` out NREQ: response available for requester i.
- `resp_ready` in NREQ: requester i consumes its response.
- `resp_data` out 80: response payload, shared by all requesters; meaningful only where `resp_valid` is set.
- `dir_put_valid` out 1: put offered to directory.
- `dir_put_ready` in 1: directory accepts put.
- `dir_put_request` out 35: payload to directory.
- `dir_get_ready` in 1: directory has a response at head.
- `dir_get_valid` out 1: dequeue directory response this cycle.
- `dir_get_response` in 80: directory response.
- `inflight` out $clog2(DEPTH+1): number of outstanding puts (tag-FIFO occupancy).
- `err_orphan` out 1: sticky; set when a response arrives with no outstanding put.

## Operation

- Directory contract: every accepted put yields exactly one response, in put order.
- Arbitration state: pointer `prio` (range 0..NREQ-1).
  - `grant` is the lowest index ≥ `prio`, cyclically, with `req_valid` set.
  - `grant` is combinational and may change while unaccepted; requesters hold valid/data until accepted.
- Put path:
  - `dir_put_valid = |req_valid && !fifo_full`.
  - `dir_put_request` = `req_data` slice of `grant`.
  - `req_ready[grant] = dir_put_valid && dir_put_ready`; all other `req_ready` bits are 0.
- On put handshake:
  - push `grant` into the tag FIFO.
  - `prio <= (grant+1) mod NREQ`.
- No handshake: `prio` unchanged.
- Response path: let `head` = tag-FIFO head.
  - `resp_valid[head] = dir_get_ready && !fifo_empty`; all other bits are 0.
  - `resp_data = dir_get_response`.
  - `dir_get_valid = dir_get_ready && !fifo_empty && resp_ready[head]`.
  - On `dir_get_valid`, pop the FIFO.
- Full: `fifo_full` blocks puts even if a pop occurs in the same cycle.
- Empty:
  - A push and a pop in the same cycle are impossible, because a pop requires a non-empty FIFO.
  - `dir_get_ready` while the FIFO is empty: `dir_get_valid` stays 0 and `err_orphan <= 1`. The flag is cleared only by reset.
- Simultaneous push and pop when not empty and not full: occupancy unchanged; pointers advance mod `DEPTH`.
- `inflight` = registered occupancy.

## Timing

- Put and response paths are combinational pass-through: zero added latency and no bubbles.
- Back-to-back puts are accepted every cycle while not full.
- FIFO push/pop and `prio` update take effect at the next rising edge.
- Reset (asserted asynchronously, at any time including mid-transaction):
  - `prio` = 0, FIFO empty, `inflight` = 0, `err_orphan` = 0.
  - Consequently all `req_ready`, `resp_valid`, `dir_put_valid` and `dir_get_valid` are 0.
  - Outstanding tags are discarded; the directory is reset by the same `RST_N`.
- Release is synchronised externally; the first put can be accepted in the first cycle after deassertion.

## Test plan

- **Single put.** Reset; req0 puts 35'h1_2345_6789 with the directory ready.
  - Same cycle: `dir_put_request` = 35'h1_2345_6789, `req_ready` = 2'b01.
  - Next cycle: `inflight` = 1.
  - Directory then returns 80'hABCD with `resp_ready[0]` = 1: `resp_valid` = 2'b01, `dir_get_valid` = 1, `inflight` back to 0.
- **Round-robin fairness.** NREQ=2; both requesters valid continuously, directory always ready.
  - Grants alternate 0,1,0,1.
  - Responses return in that order to `resp_valid` 01,10,01,10.
- **Full FIFO.** DEPTH=4; four puts, no responses.
  - `inflight` = 4 and `dir_put_valid` = 0 with `req_valid` high.
  - Release one response while a put is pending: put is still blocked that cycle and accepted the next cycle.
- **Response backpressure.** Head tag = 1, `dir_get_ready` = 1, `resp_ready[1]` = 0 for 3 cycles.
  - `resp_valid` = 2'b10 held and `dir_get_valid` = 0.
  - Raise `resp_ready[1]`: dequeue in that cycle.
- **Orphan response.** FIFO empty; pulse `dir_get_ready`.
  - `err_orphan` = 1 from the next cycle onward.
  - `dir_get_valid` = 0 and all `resp_valid` = 0.
- **Reset mid-operation.** Assert `RST_N` = 0 asynchronously with 3 outstanding puts.
  - Outputs go to reset values immediately, without waiting for an edge; `inflight` = 0.
  - After release, a put from req1 is granted first only if req0 is idle, since `prio` = 0.
